run_dump_ctrl: RTL and testbench

//  Synthesizable run/observe controller for the SoC; successor to the fixed-delay sim harness.

---
 rtl/run_dump_ctrl.sv | 164 ++++++++++++++++
 tb/tb_run_dump_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_dump_ctrl.sv
// Purpose : hold the SoC in reset, run it until halt or cycle budget, then stream regfile/PROGMEM words out.
// Latency : RESET lasts RST_CYCLES, RUN at most RUN_CYCLES; each dump word takes REQ + one or more OUT cycles.
// Backpr. : out_valid/out_data/out_tag hold while out_ready is low; the next read issues only after the handshake.
//
// Ports: clk/rst (sync, active-low) | start pulse | cpu_rst (active-high), cpu_halt, cycle from the SoC |
//        rd_sel/rd_addr/rd_data debug read port (data one cycle after address) |
//        out_valid/out_ready/out_data/out_tag dump stream | busy, done, timeout status.
// Option : define CYCLE_TRACE_EN to append one word holding the SoC cycle count at RUN exit (tag 10'h3FF).
module run_dump_ctrl #(
    parameter int RST_CYCLES = 5,
    parameter int RUN_CYCLES = 500,
    parameter int NREGS      = 7,
    parameter int MEM_BASE   = 250,
    parameter int NWORDS     = 1,
    parameter int AW         = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          cpu_rst,
    input  logic          cpu_halt,
    input  logic [31:0]   cycle,
    output logic          rd_sel,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [9:0]    out_tag,
    output logic          busy,
    output logic          done,
    output logic          timeout
);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_REQ, S_OUT, S_DONE} state_t;

    localparam logic [1:0] PH_REG = 2'd0;
    localparam logic [1:0] PH_MEM = 2'd1;
    localparam logic [1:0] PH_TRC = 2'd2;

`ifdef CYCLE_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
    logic [31:0] cyc_q;
`else
    localparam bit TRACE_EN = 1'b0;
    logic [31:0] cyc_q;
    logic        unused_cycle;
    assign unused_cycle = ^cycle;
`endif

    state_t      state, nxt;
    logic [31:0] cnt;
    logic [1:0]  phase, nxt_phase;
    logic [9:0]  idx, nxt_idx;
    logic        last;
    logic        fresh;      // first OUT cycle: rd_data is live, afterwards hold carries it
    logic [31:0] hold;
    logic        timeout_q;
    logic        run_exit;
    logic [31:0] src_data;

    assign run_exit = (state == S_RUN) && (cpu_halt || (cnt == 32'(RUN_CYCLES - 1)));
    assign src_data = (phase == PH_TRC) ? cyc_q : rd_data;

    // Item sequencing: which item follows the current one, and whether it is the final one.
    always_comb begin
        nxt_phase = phase;
        nxt_idx   = idx + 10'd1;
        last      = 1'b0;
        case (phase)
            PH_REG: if (idx == 10'(NREGS - 1)) begin
                nxt_idx = '0;
                if (NWORDS > 0)    nxt_phase = PH_MEM;
                else if (TRACE_EN) nxt_phase = PH_TRC;
                else               last      = 1'b1;
            end
            PH_MEM: if (idx == 10'(NWORDS - 1)) begin
                nxt_idx = '0;
                if (TRACE_EN) nxt_phase = PH_TRC;
                else          last      = 1'b1;
            end
            default: last = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) nxt = S_RESET;
            S_RESET:        if (cnt == 32'(RST_CYCLES - 1)) nxt = S_RUN;
            S_RUN:          if (run_exit) nxt = S_REQ;
            S_REQ:          nxt = S_OUT;
            S_OUT:          if (out_ready) nxt = last ? S_DONE : S_REQ;
            default:        nxt = S_IDLE;
        endcase
    end

    // Counters, item pointer and captured data
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            phase     <= PH_REG;
            idx       <= '0;
            fresh     <= 1'b0;
            hold      <= '0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            fresh <= (state == S_REQ);
            if (state == S_OUT && fresh) hold <= src_data;
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    cnt       <= '0;
                    timeout_q <= 1'b0;
                end
                S_RESET: cnt <= (cnt == 32'(RST_CYCLES - 1)) ? '0 : cnt + 32'd1;
                S_RUN: begin
                    cnt <= cnt + 32'd1;
                    if (run_exit) begin
                        // halt has priority over the budget in the same cycle
                        timeout_q <= !cpu_halt;
                        cyc_q     <= TRACE_EN ? cycle : '0;
                        phase     <= PH_REG;
                        idx       <= '0;
                    end
                end
                S_OUT: if (out_ready) begin
                    phase <= nxt_phase;
                    idx   <= nxt_idx;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        cpu_rst   = (state != S_RUN);
        busy      = (state == S_RESET) || (state == S_RUN) || (state == S_REQ) || (state == S_OUT);
        done      = (state == S_DONE);
        timeout   = timeout_q;
        out_valid = (state == S_OUT);
        out_data  = (state == S_OUT && fresh) ? src_data : hold;
        out_tag   = (phase == PH_TRC) ? 10'h3FF : {phase == PH_MEM, idx[8:0]};
        rd_sel    = 1'b0;
        rd_addr   = '0;
        if (state == S_REQ) begin
            if (phase == PH_MEM) begin
                rd_sel  = 1'b1;
                rd_addr = AW'(32'(MEM_BASE) + 32'(idx));   // wraps modulo 2^AW
            end else if (phase == PH_REG) begin
                rd_addr = AW'(idx);
            end
        end
    end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Purpose : self-checking bench for run_dump_ctrl with a small SoC/debug-memory model and a word scoreboard.
// Latency : n/a (bench).
// Backpr. : drives out_ready always-high or 1-of-3 to exercise stalls.
module tb_run_dump_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, cpu_rst, cpu_halt, rd_sel, out_valid, out_ready, busy, done, timeout;
    logic [31:0] cycle, rd_data, out_data;
    logic [8:0]  rd_addr;
    logic [9:0]  out_tag;

`ifdef CYCLE_TRACE_EN
    localparam int NW = 9;
`else
    localparam int NW = 8;
`endif

    run_dump_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
        .cycle(cycle), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy), .done(done), .timeout(timeout)
    );

    // SoC model: cycle counter runs while out of reset; halts at its 120th run cycle when enabled.
    logic [31:0] soc_cyc = 32'd0;
    logic        halt_en = 1'b1;
    always @(posedge clk) begin
        soc_cyc <= cpu_rst ? 32'd0 : soc_cyc + 32'd1;
        rd_data <= rd_sel ? (32'hA000_0000 | {23'b0, rd_addr}) : (32'h5000_0000 | {23'b0, rd_addr});
    end
    assign cycle    = soc_cyc;
    assign cpu_halt = halt_en && !cpu_rst && (soc_cyc == 32'd119);

    int ready_mode = 0;
    int rph = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rph = (rph + 1) % 3;
            out_ready = (ready_mode == 0) || (rph == 0);
        end
    end

    typedef struct {
        logic [9:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, passes = 0, hs_cnt = 0, low_cnt = 0;
    logic        stalled = 1'b0;
    logic [31:0] last_data;
    logic [9:0]  last_tag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // Monitor: counts cpu_rst-low cycles, checks stall stability and pops the scoreboard on handshakes.
    always @(negedge clk) begin
        if (!cpu_rst) low_cnt++;
        if (rst && out_valid) begin
            if (stalled) begin
                chk("stall_data", out_data, last_data);
                chk("stall_tag", 32'(out_tag), 32'(last_tag));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got tag %0h data %0h, required no word", out_tag, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_tag", 32'(out_tag), 32'(mon_e.tag));
                    chk("word_data", out_data, mon_e.data);
                end
                hs_cnt++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                last_data = out_data;
                last_tag  = out_tag;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_dump(input int trc);
        for (int i = 0; i < 7; i++) exp_q.push_back('{10'(i), 32'h5000_0000 + 32'(i)});
        exp_q.push_back('{10'h200, 32'hA000_00FA});
`ifdef CYCLE_TRACE_EN
        exp_q.push_back('{10'h3FF, 32'(trc)});
`else
        if (trc < 0) $display("negative trace value %0d", trc);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
    endtask

    int hs0;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        chk("rst_rd_addr", {22'b0, rd_sel, rd_addr}, 32'd0);
        rst = 1'b1;

        // 1: halt at the 120th run cycle, ready always high
        push_dump(119);
        low_cnt = 0;
        hs0 = hs_cnt;
        pulse_start();
        wait_done("t1");
        chk("t1_run_cycles", 32'(low_cnt), 32'd120);
        chk("t1_timeout", {31'b0, timeout}, 32'd0);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        chk("t1_words", 32'(hs_cnt - hs0), 32'(NW));
        chk("t1_queue", 32'(exp_q.size()), 32'd0);

        // 2 + 4: no halt -> budget timeout; start pulses in RUN and DUMP are ignored
        halt_en = 1'b0;
        push_dump(499);
        low_cnt = 0;
        hs0 = hs_cnt;
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        begin
            int n = 0;
            while (!out_valid && n < 3000) begin
                @(negedge clk);
                n++;
            end
            #1;
            chk("t2_reach_dump", {31'b0, out_valid}, 32'd1);
        end
        pulse_start();
        wait_done("t2");
        chk("t2_run_cycles", 32'(low_cnt), 32'd500);
        chk("t2_timeout", {31'b0, timeout}, 32'd1);
        chk("t2_words", 32'(hs_cnt - hs0), 32'(NW));
        chk("t2_queue", 32'(exp_q.size()), 32'd0);

        // 4 + 3: start in DONE restarts and clears flags; then stalled dump with 1-of-3 ready
        halt_en = 1'b1;
        ready_mode = 1;
        push_dump(119);
        low_cnt = 0;
        hs0 = hs_cnt;
        pulse_start();
        chk("t4_done_cleared", {31'b0, done}, 32'd0);
        chk("t4_timeout_cleared", {31'b0, timeout}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd1);
        wait_done("t3");
        chk("t3_run_cycles", 32'(low_cnt), 32'd120);
        chk("t3_timeout", {31'b0, timeout}, 32'd0);
        chk("t3_words", 32'(hs_cnt - hs0), 32'(NW));
        chk("t3_queue", 32'(exp_q.size()), 32'd0);

        // 5: reset while the third word is being fetched, then a full fresh dump
        ready_mode = 0;
        push_dump(119);
        hs0 = hs_cnt;
        pulse_start();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!((hs_cnt == hs0 + 2) && !out_valid) && n < 3000);
            chk("t5_reach_word3", 32'(hs_cnt - hs0), 32'd2);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        exp_q.delete();
        rst = 1'b1;
        push_dump(119);
        low_cnt = 0;
        hs0 = hs_cnt;
        pulse_start();
        wait_done("t5");
        chk("t5_words", 32'(hs_cnt - hs0), 32'(NW));
        chk("t5_queue", 32'(exp_q.size()), 32'd0);
        chk("t5_run_cycles", 32'(low_cnt), 32'd120);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
